// File: rtl/i2s_adc_capture.sv
// I2S / left-justified ADC capture: synchronizes the codec serial lines into clk,
// deserializes one slot word at a time and writes selected PCM samples to a FIFO.
module i2s_adc_capture #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned I2S_MODE    = 1,
  parameter int unsigned CHANNEL_SEL = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_enable,
  input  logic                  i_aud_bclk,
  input  logic                  i_aud_adclrck,
  input  logic                  i_aud_adcdat,
  input  logic                  i_fifo_full,
  input  logic                  i_clear_ovf,
  output logic [DATA_WIDTH-1:0] o_sample_data,
  output logic                  o_sample_wr,
  output logic                  o_overflow,
  output logic [15:0]           o_overflow_cnt
);

  localparam int unsigned CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_SHIFT, S_HOLD} state_t;

  state_t                r_state, w_state_nxt, w_state_eff;
  logic [2:0]            r_bclk_sync, r_lrck_sync;
  logic [1:0]            r_dat_sync;
  logic                  w_bclk_rise, w_lrck_fall, w_lrck_rise, w_bit;
  logic                  r_slot, w_slot_nxt;
  logic [CW-1:0]         r_bit_cnt, w_bit_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_shreg, w_shreg_nxt;
  logic [DATA_WIDTH-1:0] r_left, r_pend_word, r_hold, w_emit_word;
  logic [DATA_WIDTH:0]   w_sum;
  logic                  r_left_valid, w_take_bit, w_latch, w_emit;
  logic                  r_pend, w_wr, w_drop;
  logic                  r_ovf;
  logic [15:0]           r_ovf_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bclk_sync <= '0;
      r_lrck_sync <= '0;
      r_dat_sync  <= '0;
    end else begin
      r_bclk_sync <= {r_bclk_sync[1:0], i_aud_bclk};
      r_lrck_sync <= {r_lrck_sync[1:0], i_aud_adclrck};
      r_dat_sync  <= {r_dat_sync[0], i_aud_adcdat};
    end
  end

  assign w_bclk_rise = r_bclk_sync[1] & ~r_bclk_sync[2];
  assign w_lrck_rise = r_lrck_sync[1] & ~r_lrck_sync[2];
  assign w_lrck_fall = ~r_lrck_sync[1] & r_lrck_sync[2];
  assign w_bit       = r_dat_sync[1];

  // An LRCK edge is applied first (w_state_eff), so a coincident BCLK rise
  // is handled as part of the freshly started slot.
  always_comb begin
    w_state_eff   = r_state;
    w_state_nxt   = r_state;
    w_slot_nxt    = r_slot;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shreg_nxt   = r_shreg;
    w_take_bit    = 1'b0;
    w_latch       = 1'b0;
    if (!i_enable) begin
      w_state_nxt   = S_IDLE;
      w_bit_cnt_nxt = '0;
      w_shreg_nxt   = '0;
    end else begin
      if ((r_state == S_IDLE) ? w_lrck_fall : (w_lrck_fall | w_lrck_rise)) begin
        w_state_eff   = S_START;
        w_slot_nxt    = w_lrck_rise;
        w_bit_cnt_nxt = '0;
        w_shreg_nxt   = '0;
      end
      w_state_nxt = w_state_eff;
      case (w_state_eff)
        S_START: begin
          if (I2S_MODE == 0) begin
            w_state_nxt = S_SHIFT;
            w_take_bit  = w_bclk_rise;
          end else if (w_bclk_rise) begin
            w_state_nxt = S_SHIFT;
          end
        end
        S_SHIFT: w_take_bit = w_bclk_rise;
        default: ;
      endcase
      if (w_take_bit) begin
        w_shreg_nxt   = {w_shreg_nxt[DATA_WIDTH-2:0], w_bit};
        w_bit_cnt_nxt = w_bit_cnt_nxt + CW'(1);
        if (w_bit_cnt_nxt == CW'(DATA_WIDTH)) begin
          w_latch     = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
    end
  end

  assign w_sum = {r_left[DATA_WIDTH-1], r_left} + {w_shreg_nxt[DATA_WIDTH-1], w_shreg_nxt};

  always_comb begin
    w_emit      = 1'b0;
    w_emit_word = w_shreg_nxt;
    if (CHANNEL_SEL == 2) begin
      w_emit      = w_latch & w_slot_nxt & r_left_valid;
      w_emit_word = w_sum[DATA_WIDTH:1];
    end else if (CHANNEL_SEL == 1) begin
      w_emit = w_latch & w_slot_nxt;
    end else begin
      w_emit = w_latch & ~w_slot_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_slot       <= 1'b0;
      r_bit_cnt    <= '0;
      r_shreg      <= '0;
      r_left       <= '0;
      r_left_valid <= 1'b0;
      r_pend       <= 1'b0;
      r_pend_word  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_slot    <= w_slot_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shreg   <= w_shreg_nxt;
      r_pend    <= w_emit;
      if (w_emit)
        r_pend_word <= w_emit_word;
      if (w_latch && !w_slot_nxt)
        r_left <= w_shreg_nxt;
      if (!i_enable)
        r_left_valid <= 1'b0;
      else if (w_latch && !w_slot_nxt)
        r_left_valid <= 1'b1;
      else if (w_lrck_fall || w_emit)
        r_left_valid <= 1'b0;
    end
  end

  // fifo_full is looked at in the strobe cycle itself, hence the pending stage.
  assign w_wr   = r_pend & ~i_fifo_full;
  assign w_drop = r_pend & i_fifo_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold    <= '0;
      r_ovf     <= 1'b0;
      r_ovf_cnt <= '0;
    end else begin
      if (w_wr)
        r_hold <= r_pend_word;
      if (w_drop) begin
        r_ovf     <= 1'b1;
        r_ovf_cnt <= i_clear_ovf ? 16'd1 : ((&r_ovf_cnt) ? r_ovf_cnt : r_ovf_cnt + 16'd1);
      end else if (i_clear_ovf) begin
        r_ovf     <= 1'b0;
        r_ovf_cnt <= '0;
      end
    end
  end

  assign o_sample_wr    = w_wr;
  assign o_sample_data  = w_wr ? r_pend_word : r_hold;
  assign o_overflow     = r_ovf;
  assign o_overflow_cnt = r_ovf_cnt;

endmodule

// File: tb/tb_i2s_adc_capture.sv
// Directed bench: three captures (I2S left, I2S mono, LJ left) on one shared
// codec bitstream, with per-instance expected-sample queues.
module tb_i2s_adc_capture;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic bclk = 1'b1, lrck = 1'b1, dat = 1'b0, full = 1'b0, clr = 1'b0;
  logic [15:0] d0, d2, dlj, oc0, oc2, oclj;
  logic w0, w2, wlj, ov0, ov2, ovlj;

  always #10 clk = ~clk;

  i2s_adc_capture #(.DATA_WIDTH(16), .I2S_MODE(1), .CHANNEL_SEL(0)) u_dut0 (
    .clk(clk), .rst(rst), .i_enable(en), .i_aud_bclk(bclk), .i_aud_adclrck(lrck),
    .i_aud_adcdat(dat), .i_fifo_full(full), .i_clear_ovf(clr),
    .o_sample_data(d0), .o_sample_wr(w0), .o_overflow(ov0), .o_overflow_cnt(oc0));
  i2s_adc_capture #(.DATA_WIDTH(16), .I2S_MODE(1), .CHANNEL_SEL(2)) u_dut2 (
    .clk(clk), .rst(rst), .i_enable(en), .i_aud_bclk(bclk), .i_aud_adclrck(lrck),
    .i_aud_adcdat(dat), .i_fifo_full(full), .i_clear_ovf(clr),
    .o_sample_data(d2), .o_sample_wr(w2), .o_overflow(ov2), .o_overflow_cnt(oc2));
  i2s_adc_capture #(.DATA_WIDTH(16), .I2S_MODE(0), .CHANNEL_SEL(0)) u_dutlj (
    .clk(clk), .rst(rst), .i_enable(en), .i_aud_bclk(bclk), .i_aud_adclrck(lrck),
    .i_aud_adcdat(dat), .i_fifo_full(full), .i_clear_ovf(clr),
    .o_sample_data(dlj), .o_sample_wr(wlj), .o_overflow(ovlj), .o_overflow_cnt(oclj));

  int unsigned cyc = 0;
  int unsigned lsb_cyc = 0;
  int vectors = 0, miscompares = 0;
  int lat0;
  bit arm_clr = 1'b0;
  logic p0 = 1'b0, p2 = 1'b0, plj = 1'b0;
  logic [15:0] last0 = '0;
  logic [15:0] q0[$], q2[$], qlj[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Raises clear_ovf for exactly the cycle the left-channel I2S drop is seen.
  initial forever begin
    @(posedge clk); #2;
    clr = arm_clr && (cyc == lsb_cyc + 3);
  end

  initial begin
    #2_000_000;
    $error("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_strobe(input string tag, input int qsize, input logic prev);
    vectors++;
    assert (qsize > 0 && !prev) else begin
      miscompares++;
      $error("FAIL %s: got strobe (queued=%0d prev_wr=%0b) expected an expected, isolated strobe", tag, qsize, prev);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (w0) begin
        chk_strobe("dut0_strobe", q0.size(), p0);
        if (q0.size() > 0) chk16("dut0_data", d0, q0.pop_front());
        lat0 = int'(cyc) - int'(lsb_cyc);
        vectors++;
        assert (lat0 >= 3 && lat0 <= 5) else begin
          miscompares++;
          $error("FAIL dut0_latency: got %0d clk expected 3..5 clk", lat0);
        end
      end
      if (w2) begin
        chk_strobe("dut2_strobe", q2.size(), p2);
        if (q2.size() > 0) chk16("dut2_data", d2, q2.pop_front());
      end
      if (wlj) begin
        chk_strobe("dutlj_strobe", qlj.size(), plj);
        if (qlj.size() > 0) chk16("dutlj_data", dlj, qlj.pop_front());
      end
    end
    p0 = w0; p2 = w2; plj = wlj;
  end

  function automatic logic [15:0] avg(input logic [15:0] a, input logic [15:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    s = s >>> 1;
    return s[15:0];
  endfunction

  function automatic logic [31:0] i2s_slot(input logic [15:0] w, input logic dead, input logic follow);
    return {dead, w, follow, 14'h2AAA};
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  // One BCLK period per bit: LRCK/data change on the falling edge, 4 clk per phase.
  task automatic send_slot(input logic lr, input logic [31:0] b, input int first, input int last);
    for (int i = first; i < last; i++) begin
      @(posedge clk); #3;
      bclk = 1'b0; lrck = lr; dat = b[31-i];
      repeat (4) @(posedge clk);
      #3;
      bclk = 1'b1;
      if (lr == 1'b0 && i == 16) lsb_cyc = cyc;
      repeat (3) @(posedge clk);
    end
  endtask

  task automatic frame_bits(input logic [31:0] lb, input logic [31:0] rb);
    if (!full) begin
      q0.push_back(lb[30:15]);
      last0 = lb[30:15];
      qlj.push_back(lb[31:16]);
      q2.push_back(avg(lb[30:15], rb[30:15]));
    end
    send_slot(1'b0, lb, 0, 32);
    send_slot(1'b1, rb, 0, 32);
  endtask

  task automatic frame(input logic [15:0] l, input logic [15:0] r);
    frame_bits(i2s_slot(l, 1'b1, 1'b0), i2s_slot(r, 1'b0, 1'b1));
  endtask

  initial begin
    logic [31:0] lb;
    wait_clk(4);
    chk16("reset_data", d0, 16'h0000);
    chk16("reset_wr", {15'b0, w0}, 16'h0000);
    chk16("reset_ovf", {15'b0, ov0}, 16'h0000);
    chk16("reset_ovf_cnt", oc0, 16'h0000);
    rst = 1'b0;
    en  = 1'b1;
    wait_clk(4);

    frame(16'h8001, 16'h7FFE);
    frame(16'h8001, 16'h7FFE);
    frame(16'h7FFF, 16'h0001);
    frame(16'hFFFF, 16'hFFFE);
    lb = {16'hA5A5, 1'b1, 15'h0};
    frame_bits(lb, i2s_slot(16'h1234, 1'b0, 1'b0));
    wait_clk(6);

    full = 1'b1;
    frame(16'h1111, 16'h2222);
    frame(16'h3333, 16'h4444);
    frame(16'h5555, 16'h6666);
    wait_clk(6);
    chk16("dut0_ovf_cnt_3", oc0, 16'd3);
    chk16("dut0_ovf_3", {15'b0, ov0}, 16'd1);
    chk16("dut2_ovf_cnt_3", oc2, 16'd3);
    chk16("dutlj_ovf_cnt_3", oclj, 16'd3);
    chk16("dut0_data_held_full", d0, last0);
    arm_clr = 1'b1;
    frame(16'h7777, 16'h8888);
    arm_clr = 1'b0;
    wait_clk(6);
    full = 1'b0;
    chk16("dut0_clr_drop_cnt", oc0, 16'd1);
    chk16("dut0_clr_drop_ovf", {15'b0, ov0}, 16'd1);
    chk16("dutlj_cleared_cnt", oclj, 16'd0);
    chk16("dutlj_cleared_ovf", {15'b0, ovlj}, 16'd0);
    chk16("dut2_clr_then_drop_cnt", oc2, 16'd1);
    frame(16'h0F0F, 16'hF0F0);

    en = 1'b0;
    wait_clk(4);
    send_slot(1'b0, i2s_slot(16'hDEAD, 1'b0, 1'b0), 0, 32);
    send_slot(1'b1, i2s_slot(16'hBEEF, 1'b0, 1'b0), 0, 10);
    en = 1'b1;
    send_slot(1'b1, i2s_slot(16'hBEEF, 1'b0, 1'b0), 10, 32);
    send_slot(1'b0, i2s_slot(16'hCAFE, 1'b1, 1'b1), 0, 10);
    send_slot(1'b1, i2s_slot(16'h0101, 1'b0, 1'b0), 0, 32);
    frame(16'h1357, 16'h2468);

    lb = i2s_slot(16'h6C6C, 1'b0, 1'b1);
    send_slot(1'b0, lb, 0, 8);
    en = 1'b0;
    wait_clk(2);
    chk16("en_low_wr", {15'b0, w0}, 16'h0000);
    chk16("en_low_data_held", d0, last0);
    send_slot(1'b0, lb, 8, 32);
    send_slot(1'b1, lb, 0, 10);
    en = 1'b1;
    send_slot(1'b1, lb, 10, 32);
    frame(16'h4321, 16'hFEDC);

    send_slot(1'b0, lb, 0, 8);
    rst = 1'b1;
    wait_clk(2);
    chk16("midrst_data", d0, 16'h0000);
    chk16("midrst_ovf_cnt", oc0, 16'h0000);
    chk16("midrst_ovf2", {15'b0, ov2}, 16'h0000);
    rst = 1'b0;
    last0 = '0;
    send_slot(1'b0, lb, 8, 32);
    send_slot(1'b1, lb, 0, 32);
    frame(16'h8000, 16'h8000);
    wait_clk(8);

    chk16("final_data_held", d0, last0);
    chk16("q0_drained", 16'(q0.size()), 16'd0);
    chk16("q2_drained", 16'(q2.size()), 16'd0);
    chk16("qlj_drained", 16'(qlj.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
